core_scheduler: RTL and testbench
=================================

// Module: core_scheduler
// PURPOSE
//  Per-core control FSM: sequences one instruction at a time through fetch,
//  decode, memory request/wait, execute and PC update for all threads of a block.
//  Drives the 3-bit core_state consumed by the decoder, which decodes when core_state==DECODE (3'b010).
//  Drives the fetcher, ALUs, LSUs and PC units. Owns the shared block PC and reports block completion.
// PARAMETERS
//  THREADS    4    threads per block (1..16)
//  PC_BITS    8    program-counter width
//  ICNT_BITS  16   retired-instruction counter width
// PORTS
//  clk            in   1                  clock
//  reset          in   1                  synchronous, active-high
//  start          in   1                  launch block; sampled only in IDLE
//  thread_enable  in   THREADS            1 = thread active in this block
//  fetch_done     in   1                  fetcher: instruction valid at decoder input
//  lsu_busy       in   THREADS            per-thread LSU request outstanding
//  dec_ret        in   1                  registered RET flag from the decoder
//  next_pc        in   THREADS*PC_BITS    per-thread next PC, thread i at [i*PC_BITS +: PC_BITS]
//  core_state     out  3                  current FSM state
//  current_pc     out  PC_BITS            PC of the instruction being processed
//  done           out  1                  block finished (sticky until reset)
//  instr_count    out  ICNT_BITS          instructions retired since start
// BEHAVIOUR
//  Reset: core_state=IDLE, current_pc=0, done=0, instr_count=0. Takes priority over every other input, in any state.
//  Encoding: IDLE=000 FETCH=001 DECODE=010 REQUEST=011 WAIT=100 EXECUTE=101 UPDATE=110 DONE=111.
//  All outputs are registered. One transition per clk edge at most.
//  IDLE:
//   - start=1, thread_enable!=0 -> FETCH; current_pc<=0, instr_count<=0.
//   - start=1, thread_enable==0 -> DONE; done<=1, instr_count stays 0.
//   - start=0 -> stay.
//  FETCH: stay until fetch_done=1, then DECODE. No timeout.
//  DECODE: exactly 1 cycle -> REQUEST. Decoder outputs are valid from REQUEST onward.
//  REQUEST: exactly 1 cycle -> WAIT. LSUs issue requests during this cycle.
//  WAIT:
//   - Stay while |(lsu_busy & thread_enable).
//   - Otherwise -> EXECUTE, including the first WAIT cycle.
//   - lsu_busy of disabled threads is ignored.
//  EXECUTE: exactly 1 cycle -> UPDATE.
//  UPDATE:
//   - dec_ret=1 -> DONE; done<=1; instr_count increments; current_pc unchanged.
//   - Else -> FETCH; current_pc<=next_pc[k], k = lowest-index enabled thread; instr_count increments.
//   - Divergent next_pc values among other threads are ignored; branch divergence is unsupported.
//  instr_count saturates at all-ones and does not wrap.
//  current_pc wraps naturally when next_pc wraps; no check.
//  DONE: hold state, done=1, current_pc and instr_count frozen. start is ignored; only reset leaves DONE.
//  start asserted outside IDLE: ignored.
//  thread_enable is sampled continuously. Changes mid-block affect WAIT and the UPDATE PC selection from that cycle.
//  thread_enable dropping to 0 mid-block:
//   - WAIT exits immediately.
//   - In UPDATE, current_pc<=0 is taken as the fallback.
//  Minimum instruction latency, with fetch_done and no LSU stall:
//   - 6 cycles from FETCH entry to next FETCH entry: FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE.
// STRUCTURE
//  Shared package gpu_pkg:
//   - typedef enum logic [2:0] core_state_t with the encodings above. The decoder's 3'b010 must match DECODE.
//   - Localparams CORE_STATE_BITS=3 and default THREADS/PC_BITS.
//  Sub-module first_active_thread:
//   - Combinational priority encoder, THREADS -> index + valid.
//   - Selects which next_pc slice is committed in UPDATE.
//  Everything else is a single always_ff FSM plus the counter.
// TESTING
//  1 Reset, start=1, en=4'b1111, fetch_done=1, no busy, dec_ret=0, next_pc all 8'h01
//     -> states 001,010,011,100,101,110,001; current_pc=1 after UPDATE; instr_count=1.
//  2 Program of 3 instructions, RET on the 3rd
//     -> done=1 and core_state=111 in the cycle after the 3rd UPDATE; instr_count=3; start pulse afterward ignored.
//  3 lsu_busy=4'b0100 for 5 cycles after REQUEST, en=4'b1111 -> exactly 5 WAIT cycles, then EXECUTE.
//     Repeat with en=4'b1011 -> zero stall cycles.
//  4 en=4'b1100, next_pc={8'h20,8'h10,8'hAA,8'hBB} (thread3..0) -> current_pc=8'h10 after UPDATE.
//     Repeat with en=4'b0000 at start -> DONE in 1 cycle, instr_count=0.
//  5 fetch_done held 0 for 10 cycles -> core_state stays 001.
//     Assert reset while in WAIT -> next cycle IDLE, current_pc=0, done=0, instr_count=0.
//  6 Force instr_count to all-ones (ICNT_BITS=4, 16 instrs + 1) -> instr_count stays 4'hF.

Source files
------------

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared core FSM state encoding and default block geometry
package gpu_pkg;

    localparam int CORE_STATE_BITS = 3;
    localparam int DEFAULT_THREADS = 4;
    localparam int DEFAULT_PC_BITS = 8;

    // DECODE must stay 3'b010: the decoder compares core_state against it.
    typedef enum logic [CORE_STATE_BITS-1:0] {
        ST_IDLE    = 3'b000,
        ST_FETCH   = 3'b001,
        ST_DECODE  = 3'b010,
        ST_REQUEST = 3'b011,
        ST_WAIT    = 3'b100,
        ST_EXECUTE = 3'b101,
        ST_UPDATE  = 3'b110,
        ST_DONE    = 3'b111
    } core_state_t;

endpackage

// File: rtl/first_active_thread.sv
// rtl/first_active_thread.sv - priority encoder picking the lowest-index enabled thread
module first_active_thread #(
    parameter int THREADS  = 4,
    parameter int IDX_BITS = (THREADS > 1) ? $clog2(THREADS) : 1
) (
    input  logic [THREADS-1:0]  thread_enable,
    output logic [IDX_BITS-1:0] idx,
    output logic                valid
);

    // Scan from the top so the lowest enabled index is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = THREADS - 1; i >= 0; i--) begin
            if (thread_enable[i]) begin
                idx   = IDX_BITS'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_scheduler.sv
// rtl/core_scheduler.sv - per-core instruction sequencer owning the shared block PC
module core_scheduler
    import gpu_pkg::*;
#(
    parameter int THREADS   = DEFAULT_THREADS,
    parameter int PC_BITS   = DEFAULT_PC_BITS,
    parameter int ICNT_BITS = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [THREADS-1:0]           thread_enable,
    input  logic                         fetch_done,
    input  logic [THREADS-1:0]           lsu_busy,
    input  logic                         dec_ret,
    input  logic [THREADS*PC_BITS-1:0]   next_pc,
    output logic [CORE_STATE_BITS-1:0]   core_state,
    output logic [PC_BITS-1:0]           current_pc,
    output logic                         done,
    output logic [ICNT_BITS-1:0]         instr_count
);

    localparam int IDX_BITS = (THREADS > 1) ? $clog2(THREADS) : 1;

    core_state_t          state, state_next;
    logic [IDX_BITS-1:0]  lead_idx;
    logic                 lead_valid;
    logic [PC_BITS-1:0]   lead_pc;
    logic                 any_enabled;
    logic                 mem_stall;

    first_active_thread #(
        .THREADS  (THREADS),
        .IDX_BITS (IDX_BITS)
    ) u_first_active (
        .thread_enable (thread_enable),
        .idx           (lead_idx),
        .valid         (lead_valid)
    );

    assign any_enabled = |thread_enable;
    assign mem_stall   = |(lsu_busy & thread_enable);

    // With no enabled thread left there is no PC to follow, so fall back to 0.
    always_comb begin
        lead_pc = '0;
        if (lead_valid) begin
            lead_pc = next_pc[int'(lead_idx)*PC_BITS +: PC_BITS];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = any_enabled ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                if (fetch_done) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE:  state_next = ST_REQUEST;
            ST_REQUEST: state_next = ST_WAIT;
            ST_WAIT: begin
                if (!mem_stall) begin
                    state_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE: state_next = ST_UPDATE;
            ST_UPDATE:  state_next = dec_ret ? ST_DONE : ST_FETCH;
            ST_DONE:    state_next = ST_DONE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            current_pc  <= '0;
            done        <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        current_pc  <= '0;
                        instr_count <= '0;
                        if (!any_enabled) begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_UPDATE: begin
                    if (instr_count != '1) begin
                        instr_count <= instr_count + 1'b1;
                    end
                    if (dec_ret) begin
                        done <= 1'b1;
                    end else begin
                        current_pc <= lead_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_state = state;

endmodule

// File: tb/tb_core_scheduler.sv
// tb/tb_core_scheduler.sv - directed self-checking bench for core_scheduler
module tb_core_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  thread_enable;
    logic        fetch_done;
    logic [3:0]  lsu_busy;
    logic        dec_ret;
    logic [31:0] next_pc;

    logic [2:0]  core_state, core_state_s;
    logic [7:0]  current_pc, current_pc_s;
    logic        done, done_s;
    logic [15:0] instr_count;
    logic [3:0]  instr_count_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    core_scheduler #(.THREADS(4), .PC_BITS(8), .ICNT_BITS(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .thread_enable (thread_enable),
        .fetch_done    (fetch_done),
        .lsu_busy      (lsu_busy),
        .dec_ret       (dec_ret),
        .next_pc       (next_pc),
        .core_state    (core_state),
        .current_pc    (current_pc),
        .done          (done),
        .instr_count   (instr_count)
    );

    core_scheduler #(.THREADS(4), .PC_BITS(8), .ICNT_BITS(4)) dut_small (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .thread_enable (thread_enable),
        .fetch_done    (fetch_done),
        .lsu_busy      (lsu_busy),
        .dec_ret       (dec_ret),
        .next_pc       (next_pc),
        .core_state    (core_state_s),
        .current_pc    (current_pc_s),
        .done          (done_s),
        .instr_count   (instr_count_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        start         = 1'b0;
        thread_enable = 4'b0000;
        fetch_done    = 1'b0;
        lsu_busy      = 4'b0000;
        dec_ret       = 1'b0;
        next_pc       = 32'h0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Starts and ends in FETCH (or DONE when ret=1) with fetch_done high and no stall.
    task automatic run_instr(input logic ret);
        repeat (5) step();
        dec_ret = ret;
        step();
        dec_ret = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (core_state !== 3'b000) begin n_bad++; $display("FAIL reset_state got %b want 000", core_state); end
        n_cmp++; if (current_pc !== 8'h00) begin n_bad++; $display("FAIL reset_pc got %h want 00", current_pc); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (instr_count !== 16'd0) begin n_bad++; $display("FAIL reset_icnt got %0d want 0", instr_count); end
    endtask

    task automatic test_basic_sequence();
        logic [2:0] exp_seq [6] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b001};
        do_reset();
        thread_enable = 4'b1111;
        fetch_done    = 1'b1;
        next_pc       = {4{8'h01}};
        launch();
        n_cmp++; if (core_state !== 3'b001) begin n_bad++; $display("FAIL seq_fetch got %b want 001", core_state); end
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (core_state !== exp_seq[i]) begin
                n_bad++; $display("FAIL seq_state[%0d] got %b want %b", i, core_state, exp_seq[i]);
            end
        end
        n_cmp++; if (current_pc !== 8'h01) begin n_bad++; $display("FAIL seq_pc got %h want 01", current_pc); end
        n_cmp++; if (instr_count !== 16'd1) begin n_bad++; $display("FAIL seq_icnt got %0d want 1", instr_count); end
    endtask

    task automatic test_ret_program();
        do_reset();
        thread_enable = 4'b1111;
        fetch_done    = 1'b1;
        next_pc       = {4{8'h05}};
        launch();
        run_instr(1'b0);
        run_instr(1'b0);
        run_instr(1'b1);
        n_cmp++; if (core_state !== 3'b111) begin n_bad++; $display("FAIL ret_state got %b want 111", core_state); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ret_done got %b want 1", done); end
        n_cmp++; if (instr_count !== 16'd3) begin n_bad++; $display("FAIL ret_icnt got %0d want 3", instr_count); end
        n_cmp++; if (current_pc !== 8'h05) begin n_bad++; $display("FAIL ret_pc got %h want 05", current_pc); end
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        n_cmp++; if (core_state !== 3'b111) begin n_bad++; $display("FAIL ret_restart_state got %b want 111", core_state); end
        n_cmp++; if (instr_count !== 16'd3) begin n_bad++; $display("FAIL ret_restart_icnt got %0d want 3", instr_count); end
    endtask

    task automatic test_lsu_stall();
        int wait_cycles;
        do_reset();
        thread_enable = 4'b1111;
        fetch_done    = 1'b1;
        next_pc       = {4{8'h02}};
        launch();
        step();
        step();
        n_cmp++; if (core_state !== 3'b011) begin n_bad++; $display("FAIL stall_req got %b want 011", core_state); end
        lsu_busy    = 4'b0100;
        wait_cycles = 0;
        repeat (5) begin
            step();
            if (core_state == 3'b100) wait_cycles++;
        end
        lsu_busy = 4'b0000;
        step();
        n_cmp++; if (wait_cycles != 5) begin n_bad++; $display("FAIL stall_wait_cycles got %0d want 5", wait_cycles); end
        n_cmp++; if (core_state !== 3'b101) begin n_bad++; $display("FAIL stall_exec got %b want 101", core_state); end

        step();
        step();
        thread_enable = 4'b1011;
        step();
        step();
        n_cmp++; if (core_state !== 3'b011) begin n_bad++; $display("FAIL nostall_req got %b want 011", core_state); end
        lsu_busy = 4'b0100;
        step();
        step();
        lsu_busy = 4'b0000;
        n_cmp++; if (core_state !== 3'b101) begin n_bad++; $display("FAIL nostall_exec got %b want 101", core_state); end
    endtask

    task automatic test_pc_select();
        do_reset();
        thread_enable = 4'b1100;
        fetch_done    = 1'b1;
        next_pc       = {8'h20, 8'h10, 8'hAA, 8'hBB};
        launch();
        run_instr(1'b0);
        n_cmp++; if (current_pc !== 8'h10) begin n_bad++; $display("FAIL pcsel_pc got %h want 10", current_pc); end
        repeat (5) step();
        thread_enable = 4'b0000;
        step();
        n_cmp++; if (current_pc !== 8'h00) begin n_bad++; $display("FAIL pcsel_fallback got %h want 00", current_pc); end
        n_cmp++; if (core_state !== 3'b001) begin n_bad++; $display("FAIL pcsel_state got %b want 001", core_state); end

        do_reset();
        thread_enable = 4'b0000;
        launch();
        n_cmp++; if (core_state !== 3'b111) begin n_bad++; $display("FAIL noen_state got %b want 111", core_state); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL noen_done got %b want 1", done); end
        n_cmp++; if (instr_count !== 16'd0) begin n_bad++; $display("FAIL noen_icnt got %0d want 0", instr_count); end
    endtask

    task automatic test_fetch_hold_and_reset();
        do_reset();
        thread_enable = 4'b1111;
        fetch_done    = 1'b0;
        next_pc       = {4{8'h33}};
        launch();
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (core_state !== 3'b001) begin n_bad++; $display("FAIL fetch_hold[%0d] got %b want 001", i, core_state); end
        end
        fetch_done = 1'b1;
        run_instr(1'b0);
        n_cmp++; if (current_pc !== 8'h33) begin n_bad++; $display("FAIL pre_reset_pc got %h want 33", current_pc); end
        lsu_busy = 4'b1111;
        repeat (4) step();
        n_cmp++; if (core_state !== 3'b100) begin n_bad++; $display("FAIL pre_reset_wait got %b want 100", core_state); end
        reset = 1'b1;
        step();
        reset    = 1'b0;
        lsu_busy = 4'b0000;
        n_cmp++; if (core_state !== 3'b000) begin n_bad++; $display("FAIL wait_reset_state got %b want 000", core_state); end
        n_cmp++; if (current_pc !== 8'h00) begin n_bad++; $display("FAIL wait_reset_pc got %h want 00", current_pc); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL wait_reset_done got %b want 0", done); end
        n_cmp++; if (instr_count !== 16'd0) begin n_bad++; $display("FAIL wait_reset_icnt got %0d want 0", instr_count); end
    endtask

    task automatic test_saturate();
        do_reset();
        thread_enable = 4'b1111;
        fetch_done    = 1'b1;
        next_pc       = {4{8'h07}};
        launch();
        repeat (15) run_instr(1'b0);
        n_cmp++; if (instr_count_s !== 4'hF) begin n_bad++; $display("FAIL sat_15 got %h want f", instr_count_s); end
        repeat (2) run_instr(1'b0);
        n_cmp++; if (instr_count_s !== 4'hF) begin n_bad++; $display("FAIL sat_17 got %h want f", instr_count_s); end
        n_cmp++; if (instr_count !== 16'd17) begin n_bad++; $display("FAIL wide_17 got %0d want 17", instr_count); end
        n_cmp++; if (core_state_s !== 3'b001) begin n_bad++; $display("FAIL sat_state got %b want 001", core_state_s); end
    endtask

    initial begin
        test_reset();
        test_basic_sequence();
        test_ret_program();
        test_lsu_stall();
        test_pc_select();
        test_fetch_hold_and_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
